axis_adder_node: RTL

NoC endpoint that consumes the operand packets injected into the mesh by the START/START2 sources and produces their sum. It accepts single-flit AXI-Stream packets from its router's local ejection port, pairs operand A and operand B by source ID, adds them and injects one result flit back toward the result sink. It is the consumer stage directly downstream of the operand injectors in the adder NoC design, and it generates the DONE pulse the top level exports.

---
 rtl/axis_adder_node_pkg.sv | 20 ++
 rtl/axis_adder_node_sync_fifo.sv | 48 ++++
 rtl/axis_adder_node.sv | 110 +++++++++++
 3 files changed

// File: rtl/axis_adder_node_pkg.sv
// Shared constants and flit type for the adder NoC result node.
package axis_adder_node_pkg;

    localparam int TDATAW      = 64;
    localparam int TIDW        = 8;
    localparam int TDESTW      = 8;
    localparam int OPQ_DEPTH   = 4;
    localparam int SRC_A_ID    = 0;
    localparam int SRC_B_ID    = 1;
    localparam int NODE_ID     = 2;
    localparam int RESULT_DEST = 3;

    typedef struct packed {
        logic [TDATAW-1:0] tdata;
        logic              tlast;
        logic [TIDW-1:0]   tid;
        logic [TDESTW-1:0] tdest;
    } axis_flit_t;

endpackage

// File: rtl/axis_adder_node_sync_fifo.sv
// Synchronous FIFO, first-word-fall-through: a written word shows on dout the cycle after the write.
module axis_sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_adder_node.sv
// Adder NoC result node: pairs operand A/B flits by TID, emits their sum as one flit.
// Optional macro ADDER_SAT_EN selects a saturating add instead of a wrapping add.
module axis_adder_node
    import axis_adder_node_pkg::*;
#(
    parameter int TDATAW      = axis_adder_node_pkg::TDATAW,
    parameter int TIDW        = axis_adder_node_pkg::TIDW,
    parameter int TDESTW      = axis_adder_node_pkg::TDESTW,
    parameter int OPQ_DEPTH   = axis_adder_node_pkg::OPQ_DEPTH,
    parameter int SRC_A_ID    = axis_adder_node_pkg::SRC_A_ID,
    parameter int SRC_B_ID    = axis_adder_node_pkg::SRC_B_ID,
    parameter int NODE_ID     = axis_adder_node_pkg::NODE_ID,
    parameter int RESULT_DEST = axis_adder_node_pkg::RESULT_DEST
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_TVALID,
    output logic              RX_TREADY,
    input  logic [TDATAW-1:0] RX_TDATA,
    input  logic              RX_TLAST,
    input  logic [TIDW-1:0]   RX_TID,
    output logic              TX_TVALID,
    input  logic              TX_TREADY,
    output logic [TDATAW-1:0] TX_TDATA,
    output logic              TX_TLAST,
    output logic [TIDW-1:0]   TX_TID,
    output logic [TDESTW-1:0] TX_TDEST,
    output logic              DONE,
    output logic [15:0]       RESULT_COUNT,
    output logic              ERR
);

    localparam logic [TIDW-1:0]   A_TID     = TIDW'(SRC_A_ID);
    localparam logic [TIDW-1:0]   B_TID     = TIDW'(SRC_B_ID);
    localparam logic [TIDW-1:0]   NODE_TID  = TIDW'(NODE_ID);
    localparam logic [TDESTW-1:0] RES_TDEST = TDESTW'(RESULT_DEST);

    logic              qa_full, qa_empty, qb_full, qb_empty;
    logic [TDATAW-1:0] qa_dout, qb_dout;
    logic              rst_done_q;
    logic              rx_hs, rx_bad, push_a, push_b;
    logic              tx_hs, pair;
    logic [TDATAW-1:0] sum;
    logic              out_valid_q;
    logic [TDATAW-1:0] out_data_q;
    logic              done_q, err_q;
    logic [15:0]       count_q;

    // Both ports: a transfer happens on a rising edge where valid && ready; a source
    // holds valid and its payload until that edge, and ready never depends on valid.
    assign RX_TREADY = rst_done_q && !qa_full && !qb_full;
    assign rx_hs     = RX_TVALID && RX_TREADY;
    assign rx_bad    = !RX_TLAST || ((RX_TID != A_TID) && (RX_TID != B_TID));
    assign push_a    = rx_hs && !rx_bad && (RX_TID == A_TID);
    assign push_b    = rx_hs && !rx_bad && (RX_TID == B_TID);

    assign tx_hs = out_valid_q && TX_TREADY;
    assign pair  = !qa_empty && !qb_empty && (!out_valid_q || TX_TREADY);

`ifdef ADDER_SAT_EN
    logic [TDATAW:0] sum_wide;
    assign sum_wide = {1'b0, qa_dout} + {1'b0, qb_dout};
    assign sum      = sum_wide[TDATAW] ? '1 : sum_wide[TDATAW-1:0];
`else
    assign sum = qa_dout + qb_dout;
`endif

    axis_sync_fifo #(.W(TDATAW), .DEPTH(OPQ_DEPTH)) u_qa (
        .clk(CLK), .rst(RST), .push(push_a), .din(RX_TDATA), .pop(pair),
        .dout(qa_dout), .full(qa_full), .empty(qa_empty)
    );

    axis_sync_fifo #(.W(TDATAW), .DEPTH(OPQ_DEPTH)) u_qb (
        .clk(CLK), .rst(RST), .push(push_b), .din(RX_TDATA), .pop(pair),
        .dout(qb_dout), .full(qb_full), .empty(qb_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rst_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            rst_done_q <= 1'b1;
            done_q     <= tx_hs;
            err_q      <= rx_hs && rx_bad;
            if (tx_hs) count_q <= count_q + 16'd1;
            // A pair can refill the output register on the same edge it drains.
            if (pair) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sum;
            end else if (tx_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign TX_TVALID    = out_valid_q;
    assign TX_TDATA     = out_data_q;
    assign TX_TLAST     = 1'b1;
    assign TX_TID       = NODE_TID;
    assign TX_TDEST     = RES_TDEST;
    assign DONE         = done_q;
    assign ERR          = err_q;
    assign RESULT_COUNT = count_q;

endmodule
